// File: rtl/fft_output_unloader_if.sv
// Signal bundle between the FFT butterfly results, the output unloader and the
// downstream sample stream. master = unloader side, slave = producer/consumer side.
interface fft_output_unloader_if #(
    parameter int unsigned N_POINTS = 4,
    parameter int unsigned DATA_W   = 16
);
    localparam int unsigned IdxW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

    logic                       fft_ready_flag;
    logic [N_POINTS*DATA_W-1:0] in_real;
    logic [N_POINTS*DATA_W-1:0] in_imag;
    logic [DATA_W-1:0]          out_real;
    logic [DATA_W-1:0]          out_imag;
    logic [IdxW-1:0]            out_index;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic                       frame_drop;
    logic                       busy;

    modport master (
        input  fft_ready_flag, in_real, in_imag, out_ready,
        output out_real, out_imag, out_index, out_valid, out_last, frame_drop, busy
    );

    modport slave (
        output fft_ready_flag, in_real, in_imag, out_ready,
        input  out_real, out_imag, out_index, out_valid, out_last, frame_drop, busy
    );
endinterface

// File: rtl/fft_output_unloader.sv
// Captures completed FFT frames into a two-bank ping-pong buffer and streams them
// out one complex sample per beat, optionally in bit-reversed index order.
module fft_output_unloader #(
    parameter int unsigned N_POINTS    = 4,
    parameter int unsigned DATA_W      = 16,
    parameter bit          BIT_REVERSE = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    fft_output_unloader_if.master bus_io
);
    localparam int unsigned     IdxW    = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
    localparam int unsigned     BusW    = N_POINTS * DATA_W;
    localparam logic [IdxW-1:0] LastPos = IdxW'(N_POINTS - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   pos_q, pos_d;
    logic              wp_q, wp_d;
    logic              rp_q, rp_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              flag_q;
    logic [BusW-1:0]   bank_real_q [2];
    logic [BusW-1:0]   bank_imag_q [2];

    logic [DATA_W-1:0] out_real_q, out_real_d;
    logic [DATA_W-1:0] out_imag_q, out_imag_d;
    logic [IdxW-1:0]   out_index_q, elem_d;
    logic              out_valid_q, out_last_q, frame_drop_q, busy_q;

    logic              capture, handshake, last_hs, drop, accept, bypass;
    logic [BusW-1:0]   src_real, src_imag;

    function automatic logic [IdxW-1:0] bitrev(input logic [IdxW-1:0] v);
        logic [IdxW-1:0] r;
        for (int unsigned i = 0; i < IdxW; i++) r[i] = v[IdxW-1-i];
        return r;
    endfunction

    assign capture   = bus_io.fft_ready_flag & ~flag_q;
    assign handshake = out_valid_q & bus_io.out_ready;
    assign last_hs   = handshake & (pos_q == LastPos);
    // A full buffer still accepts when the head frame frees its bank this cycle.
    assign drop      = capture & (cnt_q == 2'd2) & ~last_hs;
    assign accept    = capture & ~drop;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        rp_d    = rp_q;
        wp_d    = accept ? ~wp_q : wp_q;
        cnt_d   = cnt_q;
        if (accept && !last_hs) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!accept && last_hs) begin
            cnt_d = cnt_q - 2'd1;
        end
        case (state_q)
            StIdle: begin
                if (cnt_d != 2'd0) begin
                    state_d = StStream;
                    pos_d   = '0;
                end
            end
            StStream: begin
                if (last_hs) begin
                    rp_d  = ~rp_q;
                    pos_d = '0;
                    if (cnt_d == 2'd0) state_d = StIdle;
                end else if (handshake) begin
                    pos_d = pos_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        elem_d     = BIT_REVERSE ? bitrev(pos_d) : pos_d;
        // The frame captured this cycle may be the next one read, before it lands in a bank.
        bypass     = accept & (wp_q == rp_d);
        src_real   = bypass ? bus_io.in_real : bank_real_q[rp_d];
        src_imag   = bypass ? bus_io.in_imag : bank_imag_q[rp_d];
        out_real_d = '0;
        out_imag_d = '0;
        for (int unsigned k = 0; k < N_POINTS; k++) begin
            if (elem_d == IdxW'(k)) begin
                out_real_d = src_real[k*DATA_W +: DATA_W];
                out_imag_d = src_imag[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pos_q        <= '0;
            wp_q         <= 1'b0;
            rp_q         <= 1'b0;
            cnt_q        <= 2'd0;
            flag_q       <= 1'b0;
            out_real_q   <= '0;
            out_imag_q   <= '0;
            out_index_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            cnt_q        <= cnt_d;
            flag_q       <= bus_io.fft_ready_flag;
            out_valid_q  <= (state_d == StStream);
            out_last_q   <= (state_d == StStream) && (pos_d == LastPos);
            frame_drop_q <= drop;
            busy_q       <= (cnt_d != 2'd0);
            if (state_d == StStream) begin
                out_real_q  <= out_real_d;
                out_imag_q  <= out_imag_d;
                out_index_q <= elem_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bank_real_q[wp_q] <= bus_io.in_real;
            bank_imag_q[wp_q] <= bus_io.in_imag;
        end
    end

    assign bus_io.out_real   = out_real_q;
    assign bus_io.out_imag   = out_imag_q;
    assign bus_io.out_index  = out_index_q;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_last   = out_last_q;
    assign bus_io.frame_drop = frame_drop_q;
    assign bus_io.busy       = busy_q;
endmodule

// File: doc/fft_output_unloader.md
# fft_output_unloader

Drains completed FFT frames from the parallel butterfly output bus and streams them out one complex sample per beat over a valid/ready interface. It sits directly downstream of the butterfly top level and is the reader for its `output_real*` / `output_imag*` / `fft_ready_flag` interface. It holds up to two frames in a ping-pong buffer, so the FFT can finish a new frame while the previous one is still streaming. It reports any frame it cannot hold.

## Interface
- `N_POINTS`, default 4: complex samples per frame; power of two, 2..16.
- `DATA_W`, default 16: width of each real and each imaginary word.
- `BIT_REVERSE`, default 0: 0 streams in index order; 1 streams in bit-reversed index order.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fft_ready_flag`  in  1  frame-complete flag from the butterfly top level; level signal.
- `in_real`  in  N_POINTS*DATA_W  flattened real results; element k at bits [k*DATA_W +: DATA_W].
- `in_imag`  in  N_POINTS*DATA_W  flattened imaginary results; same packing as `in_real`.
- `out_real`  out  DATA_W  streamed real word.
- `out_imag`  out  DATA_W  streamed imaginary word.
- `out_index`  out  log2(N_POINTS)  source element index of the current beat.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts the beat.
- `out_last`  out  1  current beat is the final beat of its frame.
- `frame_drop`  out  1  one-cycle pulse when a completed frame is discarded.
- `busy`  out  1  at least one frame is buffered.

## Operation
- **Edge detect.**
  - `ready_d` is a register holding `fft_ready_flag` from the previous cycle; it resets to 0.
  - A capture event occurs in any cycle where `fft_ready_flag`=1 and `ready_d`=0.
  - If the flag is already high when reset releases, that counts as an edge, and capture happens on the first clock after reset.
- **Buffer.**
  - Two frame banks, a write pointer `wp`, a read pointer `rp`, and a 2-bit occupancy count `cnt` (0..2).
  - On a capture, the full `in_real`/`in_imag` buses are written to bank `wp`, then `wp` toggles and `cnt` increments.
- **Drop.**
  - If a capture event occurs while `cnt`=2 and the head frame is not completing in that same cycle, the new frame is discarded.
  - `frame_drop`=1 for exactly that one cycle; the bank contents, `wp` and `cnt` are unchanged.
- **Read FSM**, states IDLE and STREAM, with a beat counter `pos` (0..N_POINTS-1):
  - IDLE: `out_valid`=0. Go to STREAM with `pos`=0 when `cnt`>0.
  - STREAM: `out_valid`=1. The beat shows element `e` of bank `rp`, where `e`=`pos` if `BIT_REVERSE`=0, or `e`=bitrev(`pos`) over log2(N_POINTS) bits if `BIT_REVERSE`=1.
    - `out_index`=`e`.
    - `out_last`=1 when `pos`=N_POINTS-1.
  - Handshake `out_valid`&`out_ready` with `pos`<N_POINTS-1: `pos` increments.
  - Handshake on the last beat: `rp` toggles and `cnt` decrements. If a frame remains, stay in STREAM with `pos`=0; otherwise go to IDLE.
- **Simultaneous capture and last-beat handshake** when `cnt`=2: the slot frees in the same cycle, so the capture is accepted (no drop) and `cnt` stays 2.
- **Stall rules.**
  - While `out_valid`=1 and `out_ready`=0, `out_real`, `out_imag`, `out_index` and `out_last` hold stable.
  - `out_valid` never deasserts before a handshake.
- **Data path.** Data passes through unmodified; no scaling, rounding or sign handling.
- `busy` = (`cnt`!=0).

## Timing
- **Reset values:** `out_valid`=0, `out_last`=0, `frame_drop`=0, `busy`=0, `out_real`=0, `out_imag`=0, `out_index`=0. `cnt`, `wp`, `rp` and `pos` are 0; the FSM is in IDLE. Bank contents are don't-care.
- **Capture latency:** capture in cycle T gives `busy`=1 and, if the buffer was empty, `out_valid`=1 with beat 0 in cycle T+1. All outputs are registered.
- **Throughput:** with `out_ready` held high, one beat per cycle, and back-to-back frames with no bubble between the last beat of one and beat 0 of the next.
- **Minimum frame time:** N_POINTS cycles; the FFT may issue one frame per N_POINTS cycles without drops.
- **Reset mid-stream:** asynchronous clear. All buffered frames are lost, the outputs take their reset values immediately, and no `frame_drop` is generated.
- **Held flag:** holding `fft_ready_flag` high for many cycles produces exactly one capture.

## Test plan
- **Single frame, `BIT_REVERSE`=0, `out_ready`=1.** Load `in_real`={40,30,20,10} (element 3..0) and `in_imag`={4,3,2,1}; pulse `fft_ready_flag` at T. Required: beats at T+1..T+4 carry real 10,20,30,40, imag 1,2,3,4, `out_index` 0,1,2,3; `out_last` only at T+4; `busy`=0 at T+5.
- **Bit-reverse.** Same frame with `BIT_REVERSE`=1. Required: `out_index` 0,2,1,3 and real 10,30,20,40.
- **Backpressure.** Drop `out_ready` for 3 cycles on beat 1. Required: beat 1 (real 20, index 1) is held stable with `out_valid`=1 for all 3 cycles; the stream then resumes; no beat is lost or duplicated.
- **Overflow.** Hold `out_ready`=0 and issue frames A, B, C with rising flag edges 2 cycles apart. Required: `frame_drop` pulses once, on C's capture cycle; raising `out_ready` then streams A then B, 8 beats, with no bubble.
- **Simultaneous free and capture.** With `cnt`=2, issue a capture edge in the same cycle as the last-beat handshake. Required: no `frame_drop`; the new frame streams after the remaining frame.
- **Reset mid-stream.** Assert `rst` during beat 2. Required: `out_valid`, `busy` and `out_last` go to 0 without waiting for a clock edge. With `fft_ready_flag` held high through the release, exactly one capture occurs on the first clock after release, and `out_valid`=1 one cycle later.
